// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto one tagged memory port.
// Round-robin on ties; write bursts hold the data path until the last beat.
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_TAG_BITS  = 5,
  parameter int MEM_DATA_BITS = 128,
  parameter int WR_BEATS      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     c_req_valid,
  output logic [1:0]                     c_req_ready,
  input  logic [1:0]                     c_req_rw,
  input  logic [2*MEM_ADDR_BITS-1:0]     c_req_addr,
  input  logic [2*(MEM_TAG_BITS-1)-1:0]  c_req_tag,
  input  logic [1:0]                     c_data_valid,
  output logic [1:0]                     c_data_ready,
  input  logic [2*MEM_DATA_BITS-1:0]     c_data_bits,
  input  logic [2*MEM_DATA_BITS/8-1:0]   c_data_mask,
  output logic [1:0]                     c_resp_valid,
  output logic [MEM_TAG_BITS-2:0]        c_resp_tag,
  output logic [MEM_DATA_BITS-1:0]       c_resp_data,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]       mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]        mem_req_tag,
  output logic                           mem_req_data_valid,
  input  logic                           mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]       mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]     mem_req_data_mask,
  input  logic                           mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]        mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]       mem_resp_data
);

  localparam int AW = MEM_ADDR_BITS;
  localparam int CT = MEM_TAG_BITS - 1;
  localparam int DW = MEM_DATA_BITS;
  localparam int MW = MEM_DATA_BITS / 8;
  localparam int CW = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WR_BEATS - 1);

  typedef enum logic {ARB = 1'b0, WDATA = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win;

  always_comb begin
    unique case (c_req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ptr_q;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    owner_d            = owner_q;
    cnt_d              = cnt_q;
    c_req_ready        = 2'b00;
    c_data_ready       = 2'b00;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_rw         = c_req_rw[win];
    mem_req_addr       = win ? c_req_addr[2*AW-1:AW] : c_req_addr[AW-1:0];
    mem_req_tag        = {win, win ? c_req_tag[2*CT-1:CT] : c_req_tag[CT-1:0]};
    mem_req_data_bits  = owner_q ? c_data_bits[2*DW-1:DW] : c_data_bits[DW-1:0];
    mem_req_data_mask  = owner_q ? c_data_mask[2*MW-1:MW] : c_data_mask[MW-1:0];
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          mem_req_valid    = |c_req_valid;
          c_req_ready[win] = mem_req_ready;
          if (mem_req_valid && mem_req_ready) begin
            ptr_d = ~win;
            if (mem_req_rw) begin
              state_d = WDATA;
              owner_d = win;
              cnt_d   = '0;
            end
          end
        end
        WDATA: begin
          mem_req_data_valid    = c_data_valid[owner_q];
          c_data_ready[owner_q] = mem_req_data_ready;
          if (mem_req_data_valid && mem_req_data_ready) begin
            if (cnt_q == LAST) state_d = ARB;
            else cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Responses bypass the FSM; the tag MSB names the client.
  always_comb begin
    c_resp_valid = 2'b00;
    if (!reset && mem_resp_valid)
      c_resp_valid[mem_resp_tag[CT]] = 1'b1;
    c_resp_tag  = mem_resp_tag[CT-1:0];
    c_resp_data = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with request/data/response scoreboards.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int TW = 5;
  localparam int CT = TW - 1;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        c_req_valid, c_req_ready, c_req_rw;
  logic [2*AW-1:0]   c_req_addr;
  logic [2*CT-1:0]   c_req_tag;
  logic [1:0]        c_data_valid, c_data_ready;
  logic [2*DW-1:0]   c_data_bits;
  logic [2*MW-1:0]   c_data_mask;
  logic [1:0]        c_resp_valid;
  logic [CT-1:0]     c_resp_tag;
  logic [DW-1:0]     c_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0]     mem_req_addr;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0]     mem_req_data_bits;
  logic [MW-1:0]     mem_req_data_mask;
  logic              mem_resp_valid;
  logic [TW-1:0]     mem_resp_tag;
  logic [DW-1:0]     mem_resp_data;

  mem_arbiter #(
    .MEM_ADDR_BITS(AW), .MEM_TAG_BITS(TW),
    .MEM_DATA_BITS(DW), .WR_BEATS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_req_rw(c_req_rw), .c_req_addr(c_req_addr), .c_req_tag(c_req_tag),
    .c_data_valid(c_data_valid), .c_data_ready(c_data_ready),
    .c_data_bits(c_data_bits), .c_data_mask(c_data_mask),
    .c_resp_valid(c_resp_valid), .c_resp_tag(c_resp_tag),
    .c_resp_data(c_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [159:0] req_q[$];
  logic [159:0] dat_q[$];
  logic [159:0] rsp_q[$];

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [159:0] ereq(input logic rw,
      input logic [AW-1:0] a, input logic [TW-1:0] t);
    return 160'({rw, a, t});
  endfunction

  function automatic logic [159:0] edat(input logic [DW-1:0] d,
      input logic [MW-1:0] m);
    return 160'({m, d});
  endfunction

  function automatic logic [159:0] ersp(input logic [1:0] v,
      input logic [CT-1:0] t, input logic [DW-1:0] d);
    return {v, t, d[DW-1:DW-26]};
  endfunction

  task automatic set_req(input int c, input logic v, input logic rw,
                         input logic [AW-1:0] a, input logic [CT-1:0] t);
    c_req_valid[c]       = v;
    c_req_rw[c]          = rw;
    c_req_addr[c*AW +: AW] = a;
    c_req_tag[c*CT +: CT]  = t;
  endtask

  task automatic set_dat(input int c, input logic v, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    c_data_valid[c]         = v;
    c_data_bits[c*DW +: DW] = d;
    c_data_mask[c*MW +: MW] = m;
  endtask

  // Pop and compare every transfer the DUT presents this cycle.
  task automatic sample();
    logic [159:0] e;
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        e = req_q.pop_front();
        chk("req", ereq(mem_req_rw, mem_req_addr, mem_req_tag), e);
      end
    end
    if (mem_req_data_valid && mem_req_data_ready) begin
      if (dat_q.size() == 0) chk("data_unexpected", 1, 0);
      else begin
        e = dat_q.pop_front();
        chk("data", edat(mem_req_data_bits, mem_req_data_mask), e);
      end
    end
    if (|c_resp_valid) begin
      if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("resp", ersp(c_resp_valid, c_resp_tag, c_resp_data), e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample();
    adv();
    reset = 1'b0;
  endtask

  logic [DW-1:0] beat [4];
  logic [MW-1:0] bmsk [4];
  bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      beat[i] = {$urandom, $urandom, $urandom, $urandom};
      bmsk[i] = 16'(16'h1111 << i);
    end
    reset = 1'b1;
    c_req_valid = '0; c_req_rw = '0; c_req_addr = '0; c_req_tag = '0;
    c_data_valid = '0; c_data_bits = '0; c_data_mask = '0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    #1;

    // Reset cycle: all handshake outputs held low despite active inputs
    c_req_valid = 2'b11; c_data_valid = 2'b11;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h13;
    sample();
    chk("rst_mem_req_valid", 160'(mem_req_valid), 0);
    chk("rst_c_req_ready", 160'(c_req_ready), 0);
    chk("rst_c_data_ready", 160'(c_data_ready), 0);
    chk("rst_mem_data_valid", 160'(mem_req_data_valid), 0);
    chk("rst_c_resp_valid", 160'(c_resp_valid), 0);
    adv();
    reset = 1'b0;
    c_req_valid = '0; c_data_valid = '0; mem_resp_valid = 1'b0;
    mem_req_data_ready = 1'b0;

    // Single icache read and its response
    set_req(0, 1, 0, 28'h100, 4'h3);
    req_q.push_back(ereq(0, 28'h100, 5'h03));
    sample();
    chk("rd_c_req_ready", 160'(c_req_ready), 160'h1);
    adv();
    set_req(0, 0, 0, 28'h0, 4'h0);
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h03;
    mem_resp_data = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    rsp_q.push_back(ersp(2'b01, 4'h3, mem_resp_data));
    sample();
    adv();
    mem_resp_valid = 1'b0;

    // Tie with ptr 0: icache then dcache
    do_reset();
    set_req(0, 1, 0, 28'h0A0, 4'h2);
    set_req(1, 1, 0, 28'h0B0, 4'h7);
    req_q.push_back(ereq(0, 28'h0A0, 5'h02));
    req_q.push_back(ereq(0, 28'h0B0, 5'h17));
    sample();
    chk("tie_ready_ic", 160'(c_req_ready), 160'h1);
    adv();
    set_req(0, 0, 0, 28'h0, 4'h0);
    sample();
    chk("tie_ready_dc", 160'(c_req_ready), 160'h2);
    adv();

    // Memory stall: nothing accepted, request stable, ptr kept
    mem_req_ready = 1'b0;
    set_req(0, 1, 0, 28'h0C0, 4'h4);
    set_req(1, 1, 0, 28'h0D0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_c_req_ready", 160'(c_req_ready), 0);
      chk("stall_mem_req", ereq(mem_req_rw, mem_req_addr, mem_req_tag),
          ereq(0, 28'h0C0, 5'h04));
      adv();
    end
    mem_req_ready = 1'b1;
    req_q.push_back(ereq(0, 28'h0C0, 5'h04));
    req_q.push_back(ereq(0, 28'h0D0, 5'h16));
    sample();
    adv();
    set_req(0, 0, 0, 28'h0, 4'h0);
    sample();
    adv();
    set_req(1, 0, 0, 28'h0, 4'h0);

    // Dcache 4-beat write with stalls; icache waits; response mid-burst
    set_req(1, 1, 1, 28'hABCDE0, 4'h5);
    req_q.push_back(ereq(1, 28'hABCDE0, 5'h15));
    sample();
    adv();
    set_req(1, 0, 0, 28'h0, 4'h0);
    set_req(0, 1, 0, 28'h200, 4'h1);
    set_dat(0, 1, {4{32'hDEADBEEF}}, 16'hFFFF);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      mem_req_data_ready = pat[i];
      set_dat(1, 1, beat[k], bmsk[k]);
      if (pat[i]) dat_q.push_back(edat(beat[k], bmsk[k]));
      if (i == 1) begin
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h19;
        mem_resp_data = {4{32'h0BADF00D}};
        rsp_q.push_back(ersp(2'b10, 4'h9, mem_resp_data));
      end
      sample();
      chk("wd_c_req_ready", 160'(c_req_ready), 0);
      chk("wd_mem_req_valid", 160'(mem_req_valid), 0);
      chk("wd_c_data_ready", 160'(c_data_ready), 160'({pat[i], 1'b0}));
      adv();
      mem_resp_valid = 1'b0;
      if (pat[i]) k++;
    end
    set_dat(1, 0, '0, '0);
    set_dat(0, 0, '0, '0);
    req_q.push_back(ereq(0, 28'h200, 5'h01));
    sample();
    chk("post_wr_c_data_ready", 160'(c_data_ready), 0);
    chk("post_wr_data_valid", 160'(mem_req_data_valid), 0);
    chk("post_wr_c_req_ready", 160'(c_req_ready), 160'h1);
    adv();
    set_req(0, 0, 0, 28'h0, 4'h0);

    // Icache write aborted by reset after two beats
    set_req(0, 1, 1, 28'h300, 4'h2);
    req_q.push_back(ereq(1, 28'h300, 5'h02));
    sample();
    adv();
    set_req(0, 0, 0, 28'h0, 4'h0);
    mem_req_data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_dat(0, 1, beat[i], bmsk[i]);
      dat_q.push_back(edat(beat[i], bmsk[i]));
      sample();
      adv();
    end
    set_dat(0, 1, beat[2], bmsk[2]);
    set_req(1, 1, 0, 28'h400, 4'hA);
    reset = 1'b1;
    sample();
    chk("abort_rst_data_ready", 160'(c_data_ready), 0);
    chk("abort_rst_req_valid", 160'(mem_req_valid), 0);
    adv();
    reset = 1'b0;
    req_q.push_back(ereq(0, 28'h400, 5'h1A));
    sample();
    chk("abort_c_data_ready", 160'(c_data_ready), 0);
    chk("abort_data_valid", 160'(mem_req_data_valid), 0);
    chk("abort_c_req_ready", 160'(c_req_ready), 160'h2);
    adv();
    set_req(1, 0, 0, 28'h0, 4'h0);
    set_dat(0, 0, '0, '0);
    sample();
    adv();

    chk("req_q_drained", 160'(req_q.size()), 0);
    chk("dat_q_drained", 160'(dat_q.size()), 0);
    chk("rsp_q_drained", 160'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 28, request address width.
REQ-002 SHALL have parameter MEM_TAG_BITS, default 5, memory-side tag width; client tags are MEM_TAG_BITS-1 wide.
REQ-003 SHALL have parameter MEM_DATA_BITS, default 128, data beat width; mask width MEM_DATA_BITS/8.
REQ-004 SHALL have parameter WR_BEATS, default 4, data beats per write request.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 c_req_valid  in  2  per-client request valid; bit 0 = icache, bit 1 = dcache.
REQ-008 c_req_ready  out  2  per-client request accept.
REQ-009 c_req_rw  in  2  per-client 1 = write, 0 = read.
REQ-010 c_req_addr  in  2*MEM_ADDR_BITS  client n in slice n.
REQ-011 c_req_tag  in  2*(MEM_TAG_BITS-1)  client n in slice n.
REQ-012 c_data_valid  in  2  per-client write-data valid.
REQ-013 c_data_ready  out  2  per-client write-data accept.
REQ-014 c_data_bits  in  2*MEM_DATA_BITS  write data, slice n.
REQ-015 c_data_mask  in  2*MEM_DATA_BITS/8  byte mask, slice n.
REQ-016 c_resp_valid  out  2  per-client response valid.
REQ-017 c_resp_tag  out  MEM_TAG_BITS-1  shared response tag.
REQ-018 c_resp_data  out  MEM_DATA_BITS  shared response data.
REQ-019 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-020 mem_req_rw  out  1;  mem_req_addr  out  MEM_ADDR_BITS;  mem_req_tag  out  MEM_TAG_BITS.
REQ-021 mem_req_data_valid / mem_req_data_ready  out / in  1 / 1  write-data handshake.
REQ-022 mem_req_data_bits  out  MEM_DATA_BITS;  mem_req_data_mask  out  MEM_DATA_BITS/8.
REQ-023 mem_resp_valid  in  1;  mem_resp_tag  in  MEM_TAG_BITS;  mem_resp_data  in  MEM_DATA_BITS (no backpressure).

Function
REQ-024 States: ARB, WDATA; one request transfers per cycle: fire = valid && ready.
REQ-025 In ARB: winner = sole valid client; if both valid, client indicated by priority pointer ptr.
REQ-026 In ARB: mem_req_* driven combinationally from winner; mem_req_tag = {winner id, client tag}; c_req_ready[winner] = mem_req_ready; loser ready = 0.
REQ-027 On any request fire, ptr <= ~winner (round-robin).
REQ-028 Write fire: ARB -> WDATA, owner <= winner, beat counter <= 0; read fire stays ARB.
REQ-029 In WDATA: mem_req_valid = 0, all c_req_ready = 0; mem_req_data_* from owner; c_data_ready[owner] = mem_req_data_ready, other 0.
REQ-030 Each data fire increments counter; fire at count WR_BEATS-1 -> ARB.
REQ-031 In ARB: mem_req_data_valid = 0, all c_data_ready = 0.
REQ-032 Response: c_resp_valid[mem_resp_tag MSB] = mem_resp_valid, same cycle; c_resp_tag = low MEM_TAG_BITS-1 bits; c_resp_data = mem_resp_data.
REQ-033 Responses route in any state, independent of request traffic.
REQ-034 Combinational request path, zero added latency; no request buffering.

Reset
REQ-035 Reset: state ARB, ptr 0 (icache first on tie), owner 0, counter 0; all ready/valid outputs 0 during reset cycle.
REQ-036 Reset mid-WDATA aborts burst; partial beats not replayed.

Verification
REQ-037 Icache read addr 0x100 tag 3, mem ready -> mem_req_tag 0x03, rw 0; resp tag 0x03 -> c_resp_valid=01, tag 3.
REQ-038 Both valid, ptr 0 -> icache fires first, dcache next cycle, tags 0x0x then 0x1x.
REQ-039 Dcache write tag 5, 4 beats, mem_req_data_ready low 2 cycles mid-burst -> icache blocked until 4th beat fires, then served.
REQ-040 mem_req_ready low 3 cycles with icache valid -> c_req_ready 0, mem_req stable, ptr unchanged.
REQ-041 Reset asserted after beat 2 of write -> next cycle ARB, data readies 0, new read accepted.
